// File: rtl/game_pkg.sv
// Shared definitions for the random-share controller: FSM state encodings,
// the generator word width and a constant-safe clog2 helper.
package game_pkg;

  localparam int RAND_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAMPLE  = 2'd1,
    ST_DELIVER = 2'd2
  } state_e;

  // Smallest r with 2**r >= v; usable in parameter expressions.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rand_share_ctrl_if.sv
// Requester-side bundle of the random-share controller: generator input,
// request/limit vectors and the registered grant outputs.
interface rand_share_ctrl_if import game_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = RAND_W
);
  localparam int ID_W = clog2(NUM_REQ);

  logic [WIDTH-1:0]         rand_in;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] limit;
  logic [NUM_REQ-1:0]       ack;
  logic [WIDTH-1:0]         rand_out;
  logic [ID_W-1:0]          out_id;
  logic                     busy;

  modport master (
    output rand_in, req, limit,
    input  ack, rand_out, out_id, busy
  );

  modport slave (
    input  rand_in, req, limit,
    output ack, rand_out, out_id, busy
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or above rrPtr_i,
// wrapping modulo NUM_REQ.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    rrPtr_i,
  output logic [ID_W-1:0]    pick_o,
  output logic               anyReq_o
);

  logic [ID_W-1:0] idx;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    pick_o   = '0;
    anyReq_o = 1'b0;
    idx      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ID_W'((int'(rrPtr_i) + k) % NUM_REQ);
      if (req_i[idx]) begin
        pick_o   = idx;
        anyReq_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rand_share_ctrl.sv
// Shares one free-running random word among requesters: round-robin grant,
// rejection sampling into [0, limit) and a bounded subtract-once fallback.
module rand_share_ctrl import game_pkg::*; #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = RAND_W,
  parameter int MAX_TRIES = 4
) (
  input  logic             clk,
  input  logic             reset,
  rand_share_ctrl_if.slave bus
);

  localparam int ID_W  = clog2(NUM_REQ);
  localparam int TRY_W = (MAX_TRIES > 1) ? clog2(MAX_TRIES) : 1;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    rrPtr_q, rrPtr_d;
  logic [ID_W-1:0]    outId_q, outId_d;
  logic [TRY_W-1:0]   tries_q, tries_d;
  logic [WIDTH-1:0]   lim_q, lim_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   randOut_q, randOut_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               busy_q, busy_d;

  logic [ID_W-1:0]    pick;
  logic               anyReq;
  logic [WIDTH-1:0]   limSlice [NUM_REQ];
  logic [WIDTH-1:0]   limMinus, mask, cand;
  logic               accept;

  for (genvar g = 0; g < NUM_REQ; g++) begin : gLimit
    assign limSlice[g] = bus.limit[g*WIDTH +: WIDTH];
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) uPicker (
    .req_i    (bus.req),
    .rrPtr_i  (rrPtr_q),
    .pick_o   (pick),
    .anyReq_o (anyReq)
  );

  // Mask covers every bit up to the MSB of lim-1, so cand < 2*lim always holds.
  always_comb begin
    limMinus = lim_q - WIDTH'(1);
    mask     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      mask[i] = |(limMinus >> i);
    end
    cand   = bus.rand_in & mask;
    accept = (lim_q == '0) || (cand < lim_q);
  end

  always_comb begin
    state_d   = state_q;
    rrPtr_d   = rrPtr_q;
    outId_d   = outId_q;
    tries_d   = tries_q;
    lim_d     = lim_q;
    result_d  = result_q;
    randOut_d = randOut_q;
    ack_d     = '0;
    case (state_q)
      ST_IDLE: begin
        if (anyReq) begin
          outId_d = pick;
          lim_d   = limSlice[pick];
          tries_d = '0;
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (!bus.req[outId_q]) begin
          state_d = ST_IDLE;
        end else if (accept) begin
          result_d = cand;
          state_d  = ST_DELIVER;
        end else if (int'(tries_q) < MAX_TRIES - 1) begin
          tries_d = tries_q + TRY_W'(1);
        end else begin
          result_d = cand - lim_q;
          state_d  = ST_DELIVER;
        end
      end
      ST_DELIVER: begin
        ack_d[outId_q] = 1'b1;
        randOut_d      = result_q;
        rrPtr_d        = (int'(outId_q) == NUM_REQ - 1) ? '0 : outId_q + ID_W'(1);
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      rrPtr_q   <= '0;
      outId_q   <= '0;
      tries_q   <= '0;
      lim_q     <= '0;
      result_q  <= '0;
      randOut_q <= '0;
      ack_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rrPtr_q   <= rrPtr_d;
      outId_q   <= outId_d;
      tries_q   <= tries_d;
      lim_q     <= lim_d;
      result_q  <= result_d;
      randOut_q <= randOut_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.rand_out = randOut_q;
  assign bus.out_id   = outId_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_rand_share_ctrl.sv
// Scoreboard bench for rand_share_ctrl: drivers queue expected grants from a
// reference model, a negedge monitor checks every ack against the queue.
module tb_rand_share_ctrl;

  localparam int NUM_REQ   = 4;
  localparam int WIDTH     = 8;
  localparam int MAX_TRIES = 4;
  localparam int CLK_HALF  = 20;

  typedef struct {
    logic [1:0] id;
    logic [7:0] val;
    logic [7:0] lim;
    int         cycleDue;
  } item_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] limits [4];
  item_t      expQ [$];
  int         errors   = 0;
  int         checks   = 0;
  int         cyc      = 0;
  int         modelPtr = 0;

  rand_share_ctrl_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus();

  assign bus.limit = {limits[3], limits[2], limits[1], limits[0]};

  rand_share_ctrl #(
    .NUM_REQ   (NUM_REQ),
    .WIDTH     (WIDTH),
    .MAX_TRIES (MAX_TRIES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #CLK_HALF clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Smallest power of two not below lim, minus one.
  function automatic logic [7:0] maskFor(input logic [7:0] lim);
    int p;
    if (lim == 8'd0) return 8'hFF;
    p = 1;
    while (p < int'(lim)) p = p * 2;
    return 8'(p - 1);
  endfunction

  function automatic logic [7:0] refResult(input logic [7:0] lim,
                                           input logic [7:0] s0, s1, s2, s3,
                                           output int n);
    logic [7:0] s [4];
    logic [7:0] m, c;
    s = '{s0, s1, s2, s3};
    m = maskFor(lim);
    c = 8'd0;
    n = MAX_TRIES;
    for (int i = 0; i < MAX_TRIES; i++) begin
      c = s[2'(i)] & m;
      if (lim == 8'd0 || c < lim) begin
        n = i + 1;
        return c;
      end
    end
    return c - lim;
  endfunction

  // Monitor: every ack seen must match the head of the expectation queue.
  always @(negedge clk) begin
    item_t it;
    if (reset === 1'b1 && bus.ack !== '0) begin
      checkOutput("ack_onehot", $countones(bus.ack), 1);
      if (expQ.size() == 0) begin
        checkOutput("unexpected_ack", int'(bus.ack), 0);
      end else begin
        it = expQ.pop_front();
        checkOutput("ack_id", int'(bus.ack), 1 << it.id);
        checkOutput("out_id", int'(bus.out_id), int'(it.id));
        checkOutput("rand_out", int'(bus.rand_out), int'(it.val));
        checkOutput("ack_cycle", cyc, it.cycleDue);
        if (it.lim != 8'd0) checkOutput("in_range", int'(bus.rand_out < it.lim), 1);
      end
    end
  end

  // One requester alone; s0..s3 are the words offered on successive SAMPLE cycles.
  task automatic applyStimulus(input logic [1:0] id, input logic [7:0] lim,
                               input logic [7:0] s0, s1, s2, s3);
    logic [7:0] s [4];
    item_t      it;
    int         n;
    bit         done;
    s = '{s0, s1, s2, s3};
    it.id  = id;
    it.lim = lim;
    it.val = refResult(lim, s0, s1, s2, s3, n);
    @(negedge clk);
    it.cycleDue = cyc + n + 2;
    expQ.push_back(it);
    bus.req[id]  = 1'b1;
    limits[id]   = lim;
    bus.rand_in  = s[0];
    done = 1'b0;
    for (int c = 1; c <= MAX_TRIES + 8 && !done; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checkOutput("busy_in_sample", int'(bus.busy), 1);
        limits[id] = 8'($urandom);
      end
      if (bus.ack[id]) begin
        bus.req[id] = 1'b0;
        done = 1'b1;
      end else begin
        bus.rand_in = (c <= MAX_TRIES) ? s[2'(c - 1)] : 8'($urandom);
      end
    end
    if (!done) begin
      checkOutput("ack_timeout", 0, 1);
      bus.req[id] = 1'b0;
      expQ.delete();
    end
    modelPtr = (int'(id) + 1) % NUM_REQ;
  endtask

  // Requesters in reqMask held high with full-range limits for nGrants grants.
  task automatic applyStream(input logic [3:0] reqMask, input int nGrants);
    logic [7:0] rv [32];
    logic [1:0] pid;
    item_t      it;
    int         ptr, base;
    bit         found;
    for (int c = 0; c < 32; c++) rv[5'(c)] = 8'($urandom);
    @(negedge clk);
    base = cyc;
    ptr  = modelPtr;
    for (int j = 0; j < nGrants; j++) begin
      found = 1'b0;
      pid   = 2'd0;
      for (int k = 0; k < NUM_REQ && !found; k++) begin
        pid = 2'((ptr + k) % NUM_REQ);
        if (reqMask[pid]) found = 1'b1;
      end
      it.id       = pid;
      it.val      = rv[5'(3 * j + 1)];
      it.lim      = 8'd0;
      it.cycleDue = base + 3 * j + 3;
      expQ.push_back(it);
      ptr = (int'(pid) + 1) % NUM_REQ;
    end
    modelPtr = ptr;
    for (int i = 0; i < NUM_REQ; i++) limits[2'(i)] = 8'd0;
    bus.req     = reqMask;
    bus.rand_in = rv[0];
    for (int c = 1; c <= 3 * nGrants; c++) begin
      @(negedge clk);
      if (c == 3 * nGrants) bus.req = '0;
      else bus.rand_in = rv[5'(c)];
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #(2 * CLK_HALF * 50000);
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset       = 1'b0;
    bus.req     = '0;
    bus.rand_in = '0;
    for (int i = 0; i < NUM_REQ; i++) limits[2'(i)] = 8'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ack", int'(bus.ack), 0);
    checkOutput("reset_busy", int'(bus.busy), 0);
    checkOutput("reset_rand_out", int'(bus.rand_out), 0);
    checkOutput("reset_out_id", int'(bus.out_id), 0);
    reset = 1'b1;
    @(negedge clk);

    // Full range, first-try acceptance.
    applyStimulus(2'd0, 8'd0, 8'hA5, 8'h00, 8'h00, 8'h00);
    // Four rejections then the subtract-once fallback: 15 - 10.
    applyStimulus(2'd1, 8'd10, 8'h0F, 8'h0F, 8'h0F, 8'h0F);
    // Rejects 12 and 14, accepts 7.
    applyStimulus(2'd2, 8'd10, 8'h0C, 8'h1E, 8'h37, 8'h00);
    applyStimulus(2'd3, 8'd200, 8'hC7, 8'h00, 8'h00, 8'h00);
    // Pointer now at 0: all four held gives 0,1,2,3,0.
    applyStream(4'b1111, 5);

    // Abort mid-SAMPLE must leave the round-robin pointer at 3.
    applyStimulus(2'd2, 8'd0, 8'h5A, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    bus.req[3]  = 1'b1;
    limits[3]   = 8'd10;
    bus.rand_in = 8'hFF;
    @(negedge clk);
    checkOutput("abort_busy_before", int'(bus.busy), 1);
    @(negedge clk);
    bus.req[3] = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy_after", int'(bus.busy), 0);
    repeat (3) @(negedge clk);
    applyStream(4'b1001, 2);

    // Asynchronous reset while sampling clears the registered outputs at once.
    applyStimulus(2'd2, 8'd0, 8'h5A, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    bus.req[1]  = 1'b1;
    limits[1]   = 8'd10;
    bus.rand_in = 8'hFF;
    @(negedge clk);
    #7 reset = 1'b0;
    #1;
    checkOutput("midreset_ack", int'(bus.ack), 0);
    checkOutput("midreset_busy", int'(bus.busy), 0);
    checkOutput("midreset_rand_out", int'(bus.rand_out), 0);
    checkOutput("midreset_out_id", int'(bus.out_id), 0);
    @(negedge clk);
    bus.req[1] = 1'b0;
    #3 reset = 1'b1;
    modelPtr = 0;
    @(negedge clk);
    applyStimulus(2'd1, 8'd1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));

    // Randomized single requests across the limit range.
    for (int t = 0; t < 30; t++) begin
      logic [7:0] lim;
      case ($urandom_range(0, 4))
        0:       lim = 8'd0;
        1:       lim = 8'd1;
        2:       lim = 8'($urandom_range(2, 15));
        3:       lim = 8'($urandom_range(100, 200));
        default: lim = 8'($urandom_range(0, 255));
      endcase
      applyStimulus(2'($urandom_range(0, 3)), lim,
                    8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    end
    for (int t = 0; t < 3; t++) begin
      applyStream(4'($urandom_range(1, 15)), $urandom_range(2, 6));
    end

    repeat (5) @(negedge clk);
    checkOutput("queue_empty", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rand_share_ctrl.md
Name: rand_share_ctrl

Overview:
- Shares the single free-running 8-bit pseudo-random generator between several game-logic requesters, e.g. enemy spawn, item placement and direction choice.
- Each requester asks for a value in its own range [0, limit).
- The block arbitrates round-robin and maps raw samples into range by rejection sampling, with a bounded deterministic fallback.
- Sits between the generator output and the game-logic blocks in the 25 MHz pixel-clock domain.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- WIDTH, 8: random word width; matches the generator output.
- MAX_TRIES, 4: samples attempted before the fallback mapping is applied (>=1).

Ports:
- clk  in  1  system clock, 25 MHz.
- reset  in  1  asynchronous, active-low reset.
- rand_in  in  WIDTH  generator output; a new value every clock.
- req  in  NUM_REQ  per-requester request level; held high until acked.
- limit  in  NUM_REQ*WIDTH  per-requester exclusive upper bound, slice i = limit[i*WIDTH +: WIDTH]; 0 means the full range.
- ack  out  NUM_REQ  one-cycle grant-complete pulse, one-hot.
- rand_out  out  WIDTH  delivered value; valid while ack is high, held until the next ack.
- out_id  out  clog2(NUM_REQ)  index of the requester being served.
- busy  out  1  high in SAMPLE and DELIVER.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, rr_ptr=0, tries=0, ack=0, rand_out=0, out_id=0, busy=0.
- FSM states: IDLE, SAMPLE, DELIVER. All outputs are registered.
- IDLE:
  - If any req bit is high, pick the first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - Latch out_id=pick, lim=limit slice, tries=0; go to SAMPLE.
  - Otherwise stay in IDLE.
- Mask computation:
  - mask = all ones from bit 0 up to the MSB of (lim-1).
  - lim=0 gives mask = all ones and every sample accepted.
  - lim=1 gives mask=0, so the result is always 0.
  - cand = rand_in & mask.
- SAMPLE, evaluated every cycle:
  - If req[out_id] is low: abort, no ack, go to IDLE, rr_ptr unchanged.
  - Else if lim=0 or cand<lim: rand_out=cand, go to DELIVER.
  - Else if tries<MAX_TRIES-1: tries+1, stay in SAMPLE (the next rand_in is used).
  - Else fallback: rand_out=cand-lim, go to DELIVER. This is always <lim because cand<2*lim.
- DELIVER:
  - ack[out_id]=1 for exactly one cycle.
  - rr_ptr=(out_id+1) mod NUM_REQ; go to IDLE.
- Latency: req high at edge k gives SAMPLE at k+1 and, on first-try acceptance, ack high in the cycle after edge k+2. The worst case is MAX_TRIES-1 cycles more.
- Handshake:
  - The requester drops req in the cycle after ack.
  - A req still high in IDLE is treated as a new request. Round-robin has already advanced, so other pending requesters win first and there is no starvation.
- Changes to limit are ignored after it is latched in IDLE.
- Requests arriving in SAMPLE or DELIVER wait; they are not lost while req is held.
- Reset asserted mid-operation: immediate return to reset values, no ack emitted.
- The result is never >=lim when lim!=0.

Decomposition:
- Shared package (game_pkg): state encodings ST_IDLE/ST_SAMPLE/ST_DELIVER, RAND_W=8, and a clog2 function.
- Sub-module rr_picker (combinational):
  - Inputs: req vector, rr_ptr.
  - Outputs: pick index, any_req.
- The mask, compare and fallback logic stays inline in rand_share_ctrl.

Test Plan:
1. Full range: req[0]=1, limit0=0, rand_in=0xA5 -> ack[0] at edge+2, rand_out=0xA5, out_id=0.
2. Rejection sampling: req[2]=1, limit2=10 (mask 0x0F), rand_in 0x0C, 0x1E, 0x37 on successive SAMPLE cycles -> rejects 12 and 14, accepts 7; ack[2] one cycle later.
3. Fallback: MAX_TRIES=4, limit1=10, rand_in held 0x0F -> 4 rejections, then rand_out=5 and ack[1].
4. Round-robin: req=4'b1111 held continuously, limits 0 -> acks in order 0, 1, 2, 3, 0, one every 3 cycles, never two bits set.
5. Abort: req[3] drops during SAMPLE (limit3=10, rand_in 0xFF) -> no ack, back to IDLE, rr_ptr unchanged; the next req[0] is served normally.
6. Reset mid-SAMPLE: reset low asynchronously -> ack=0, busy=0, rand_out=0 immediately; after release, req[1] with limit 1 -> rand_out=0 and ack[1].
